object_launcher2: RTL and testbench

//   Producer side of the two-object motion interface. Picks pseudo-random launch position, velocity and direction for

---
 rtl/object_launcher2.sv | 200 ++++++++++++++++++++
 tb/tb_object_launcher2.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/object_launcher2.sv
// object_launcher2: producer side of the two-object motion interface.
// Each of the two slots cycles IDLE -> WAIT -> LOAD -> FLY -> WAIT ... .
// WAIT counts down a pseudo-random number of ticks. LOAD issues a one-cycle
// re-init pulse and latches fresh launch parameters from a shared LFSR.
// FLY enables motion until the object leaves the screen or is sliced.
module object_launcher2 #(
  parameter int          SCREEN_W  = 640,
  parameter int          SCREEN_H  = 480,
  parameter int          OBJ_H     = 48,
  parameter int          X_MARGIN  = 64,
  parameter int          VY_BASE   = 12,
  parameter int          GRAVITY   = 1,
  parameter int          DELAY_MIN = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       tick,
  input  logic       oob1,
  input  logic       oob2,
  input  logic       hit1,
  input  logic       hit2,
  output logic       load1,
  output logic       load2,
  output logic       moveen1,
  output logic       moveen2,
  output logic [9:0] initposx1,
  output logic [9:0] initposx2,
  output logic [9:0] initposy1,
  output logic [9:0] initposy2,
  output logic [9:0] initvx1,
  output logic [9:0] initvx2,
  output logic [9:0] initvy1,
  output logic [9:0] initvy2,
  output logic       initdx1,
  output logic       initdx2,
  output logic       initdy1,
  output logic       initdy2,
  output logic [9:0] ax1,
  output logic [9:0] ax2,
  output logic [9:0] ay1,
  output logic [9:0] ay2,
  output logic [1:0] adx1,
  output logic [1:0] adx2,
  output logic [1:0] ady1,
  output logic [1:0] ady2
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;
  localparam logic [1:0] ST_FLY  = 2'd3;

  // A zero seed would lock the LFSR up, so it is replaced by the default.
  localparam logic [15:0] SEED    = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [7:0]  DLY_MIN = 8'(DELAY_MIN);

  typedef struct packed {
    logic [9:0] posx;
    logic [9:0] posy;
    logic [9:0] vx;
    logic [9:0] vy;
    logic       dx;
    logic       dy;
    logic [9:0] ax;
    logic [9:0] ay;
    logic [1:0] adx;
    logic [1:0] ady;
  } launch_t;

  logic [15:0]      lfsr;
  logic [1:0][1:0]  state;
  logic [1:0][1:0]  state_nx;
  logic [1:0][7:0]  dcnt;
  logic [1:0]       oob_q;
  logic [1:0]       oob_in;
  logic [1:0]       hit_in;
  logic [1:0]       oob_rise;
  logic [1:0]       load_req;
  logic [1:0]       grant;
  logic [1:0]       fly_exit;
  logic [1:0]       wait_entry;
  launch_t          launch_nx;
  launch_t [1:0]    launch_q;

  assign oob_in   = {oob2, oob1};
  assign hit_in   = {hit2, hit1};
  assign oob_rise = oob_in & ~oob_q;

  // A slot asks to load once its countdown has reached zero in WAIT.
  assign load_req = {(state[1] == ST_WAIT) && (dcnt[1] == 8'd0),
                     (state[0] == ST_WAIT) && (dcnt[0] == 8'd0)};

  // Only one load per cycle: slot 1 wins, slot 2 retries the next cycle.
  assign grant = {load_req[1] & ~load_req[0], load_req[0]};

  // Leaving flight: fresh out-of-bound edge or a slice, counted once.
  assign fly_exit = {(state[1] == ST_FLY) && (oob_rise[1] || hit_in[1]),
                     (state[0] == ST_FLY) && (oob_rise[0] || hit_in[0])};

  // Every entry into WAIT reloads the countdown.
  assign wait_entry = {2{en}} & (fly_exit | {state[1] == ST_IDLE, state[0] == ST_IDLE});

  // Free-running Fibonacci LFSR (taps 16,14,13,11), advances even while en=0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) lfsr <= SEED;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Launch parameters derived from the current LFSR word.
  always_comb begin
    // NOTE: a full default first keeps combinational blocks from inferring latches.
    launch_nx      = '0;
    launch_nx.posx = 10'(X_MARGIN) + {1'b0, lfsr[8:0]};
    launch_nx.posy = 10'(SCREEN_H - OBJ_H);
    launch_nx.vx   = {7'b0, lfsr[11:9]} + 10'd1;
    launch_nx.vy   = 10'(VY_BASE) + {7'b0, lfsr[14:12]};
    launch_nx.dx   = (launch_nx.posx < 10'(SCREEN_W / 2));
    launch_nx.dy   = 1'b0;
    launch_nx.ax   = 10'd0;
    launch_nx.adx  = 2'b00;
    launch_nx.ay   = 10'(GRAVITY);
    launch_nx.ady  = 2'b11;
  end

  // Per-slot next-state; a low en overrides everything and parks the slot.
  always_comb begin
    state_nx = state;
    for (int i = 0; i < 2; i++) begin
      case (state[i])
        ST_IDLE: state_nx[i] = ST_WAIT;
        ST_WAIT: if (grant[i]) state_nx[i] = ST_LOAD;
        ST_LOAD: state_nx[i] = ST_FLY;
        ST_FLY:  if (fly_exit[i]) state_nx[i] = ST_WAIT;
        default: state_nx[i] = ST_IDLE;
      endcase
      if (!en) state_nx[i] = ST_IDLE;
    end
  end

  // State, countdown and oob edge sampler. The sampler follows oob every
  // cycle, so in LOAD it already holds the present level and a level that is
  // high at launch does not count as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
      dcnt  <= '0;
      oob_q <= '0;
    end else begin
      state <= state_nx;
      oob_q <= oob_in;
      for (int i = 0; i < 2; i++) begin
        if (wait_entry[i])
          dcnt[i] <= DLY_MIN + {4'b0, lfsr[3:0]};
        else if (en && tick && (state[i] == ST_WAIT) && (dcnt[i] != 8'd0))
          dcnt[i] <= dcnt[i] - 8'd1;
      end
    end
  end

  // Launch registers capture during LOAD and hold otherwise (including en=0).
  always_ff @(posedge clk) begin
    if (rst) begin
      launch_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (state[i] == ST_LOAD) launch_q[i] <= launch_nx;
    end
  end

  assign load1     = (state[0] == ST_LOAD);
  assign load2     = (state[1] == ST_LOAD);
  assign moveen1   = (state[0] == ST_FLY);
  assign moveen2   = (state[1] == ST_FLY);

  assign initposx1 = launch_q[0].posx;
  assign initposy1 = launch_q[0].posy;
  assign initvx1   = launch_q[0].vx;
  assign initvy1   = launch_q[0].vy;
  assign initdx1   = launch_q[0].dx;
  assign initdy1   = launch_q[0].dy;
  assign ax1       = launch_q[0].ax;
  assign ay1       = launch_q[0].ay;
  assign adx1      = launch_q[0].adx;
  assign ady1      = launch_q[0].ady;

  assign initposx2 = launch_q[1].posx;
  assign initposy2 = launch_q[1].posy;
  assign initvx2   = launch_q[1].vx;
  assign initvy2   = launch_q[1].vy;
  assign initdx2   = launch_q[1].dx;
  assign initdy2   = launch_q[1].dy;
  assign ax2       = launch_q[1].ax;
  assign ay2       = launch_q[1].ay;
  assign adx2      = launch_q[1].adx;
  assign ady2      = launch_q[1].ady;

endmodule

// File: tb/tb_object_launcher2.sv
// Bench for object_launcher2: randomized flight exits, scoreboarded load
// timing and launch values against a cycle-indexed LFSR/tick model.
`timescale 1ns/1ps
module tb_object_launcher2;

  localparam int          DELAY_MIN  = 8;
  localparam int          MAXC       = 16384;
  localparam logic [15:0] MODEL_SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, tick = 1'b0;
  logic oob1 = 1'b0, oob2 = 1'b0, hit1 = 1'b0, hit2 = 1'b0;
  logic       load1, load2, moveen1, moveen2;
  logic [9:0] initposx1, initposx2, initposy1, initposy2;
  logic [9:0] initvx1, initvx2, initvy1, initvy2;
  logic       initdx1, initdx2, initdy1, initdy2;
  logic [9:0] ax1, ax2, ay1, ay2;
  logic [1:0] adx1, adx2, ady1, ady2;

  object_launcher2 #(.LFSR_SEED(16'h0000)) dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick),
    .oob1(oob1), .oob2(oob2), .hit1(hit1), .hit2(hit2),
    .load1(load1), .load2(load2), .moveen1(moveen1), .moveen2(moveen2),
    .initposx1(initposx1), .initposx2(initposx2),
    .initposy1(initposy1), .initposy2(initposy2),
    .initvx1(initvx1), .initvx2(initvx2), .initvy1(initvy1), .initvy2(initvy2),
    .initdx1(initdx1), .initdx2(initdx2), .initdy1(initdy1), .initdy2(initdy2),
    .ax1(ax1), .ax2(ax2), .ay1(ay1), .ay2(ay2),
    .adx1(adx1), .adx2(adx2), .ady1(ady1), .ady2(ady2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;                 // index of the current clock period since reset
  logic [15:0] lf [MAXC];        // expected LFSR value during each cycle
  int q1[$], q2[$];              // expected "countdown reaches zero" cycles

  // Cycle counter: cycle 0 is the first period with rst low.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  function automatic logic [15:0] lfsr_step(logic [15:0] v);
    // feedback = parity of bits 16,14,13,11 (1-based), shifted in at the bottom
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  function automatic logic tick_at(int k);
    return (k % 4) == 1;
  endfunction

  // WAIT entered at the end of cycle h: cycle in which the countdown reads zero.
  function automatic int elig(int h);
    int d;
    int k;
    d = DELAY_MIN + int'(lf[h][3:0]);
    k = h + 1;
    while (d > 0) begin
      if (tick_at(k)) d--;
      k++;
    end
    return k;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_launch(string tag, logic [15:0] v,
                              logic [9:0] px, logic [9:0] py, logic [9:0] vx, logic [9:0] vy,
                              logic dx, logic dy, logic [9:0] ax, logic [9:0] ay,
                              logic [1:0] adx, logic [1:0] ady);
    int ex_px;
    ex_px = 64 + int'(v[8:0]);
    check({tag, "_posx"}, px, ex_px);
    check({tag, "_vx"}, vx, int'(v[11:9]) + 1);
    check({tag, "_vy"}, vy, 12 + int'(v[14:12]));
    check({tag, "_dx"}, dx, ex_px < 320);
    check({tag, "_fixed"}, {py, dy, ax, adx, ay, ady},
          {10'd432, 1'b0, 10'd0, 2'b00, 10'd1, 2'b11});
  endtask

  // Tick timebase, one cycle in four.
  always @(posedge clk) begin
    #1;
    tick = tick_at(cyc);
  end

  // Monitor: pops the scoreboard whenever a load pulse appears.
  int          chk1 = -1, chk2 = -1, last_l1 = -100, e1, e2, exp_l2;
  logic [15:0] chk1_v, chk2_v;
  always @(negedge clk) begin
    if (rst) begin
      chk1 = -1;
      chk2 = -1;
    end else begin
      if (chk1 == cyc) begin
        check("moveen1_after_load", moveen1, 1'b1);
        check_launch("launch1", chk1_v, initposx1, initposy1, initvx1, initvy1,
                     initdx1, initdy1, ax1, ay1, adx1, ady1);
        chk1 = -1;
      end
      if (chk2 == cyc) begin
        check("moveen2_after_load", moveen2, 1'b1);
        check_launch("launch2", chk2_v, initposx2, initposy2, initvx2, initvy2,
                     initdx2, initdy2, ax2, ay2, adx2, ady2);
        chk2 = -1;
      end
      if (load1) begin
        if (q1.size() == 0) begin
          check("load1_unexpected", {63'b0, load1}, 64'd0);
        end else begin
          e1 = q1.pop_front();
          check("load1_cycle", cyc, e1 + 1);
          last_l1 = e1 + 1;
        end
        chk1   = cyc + 1;
        chk1_v = lf[cyc];
      end else if (q1.size() > 0 && cyc > q1[0] + 1) begin
        check("load1_missing", cyc, q1[0] + 1);
        void'(q1.pop_front());
      end
      if (load2) begin
        if (q2.size() == 0) begin
          check("load2_unexpected", {63'b0, load2}, 64'd0);
        end else begin
          e2 = q2.pop_front();
          exp_l2 = (e2 + 1 == last_l1) ? e2 + 2 : e2 + 1;
          check("load2_cycle", cyc, exp_l2);
        end
        chk2   = cyc + 1;
        chk2_v = lf[cyc];
      end else if (q2.size() > 0 && cyc > q2[0] + 2) begin
        check("load2_missing", cyc, q2[0] + 2);
        void'(q2.pop_front());
      end
    end
  end

  task automatic wait_both_fly(string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(moveen1 && moveen2) && n < 3000);
    check({tag, "_fly"}, {moveen1, moveen2}, 2'b11);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_ctl"}, {load1, load2, moveen1, moveen2}, 4'b0);
    check({tag, "_s1a"}, {initposx1, initposy1, initvx1, initvy1, initdx1, initdy1}, 0);
    check({tag, "_s1b"}, {ax1, ay1, adx1, ady1}, 0);
    check({tag, "_s2a"}, {initposx2, initposy2, initvx2, initvy2, initdx2, initdy2}, 0);
    check({tag, "_s2b"}, {ax2, ay2, adx2, ady2}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int act;
    lf[0] = MODEL_SEED;
    for (int i = 1; i < MAXC; i++) lf[i] = lfsr_step(lf[i-1]);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // en low after reset: nothing may move
    act = 0;
    repeat (20) begin
      @(negedge clk);
      act += int'(load1) + int'(load2) + int'(moveen1) + int'(moveen2);
    end
    check("idle_stays_idle", act, 0);

    // enable: both slots share one countdown and collide at LOAD
    @(posedge clk);
    #1 en = 1'b1;
    q1.push_back(elig(cyc));
    q2.push_back(elig(cyc));
    wait_both_fly("first_launch");

    for (int r = 0; r < 10; r++) begin
      int h1, h2, k1, k2, len1, len2, falls;
      logic prev_mv1;
      if (r > 0) wait_both_fly("round");
      h1   = (r == 0) ? 0 : $urandom_range(0, 20);
      h2   = ($urandom_range(0, 2) == 0) ? h1 : $urandom_range(0, 20);
      k1   = (r == 0) ? 1 : $urandom_range(0, 2);   // 0 hit, 1 oob, 2 both
      k2   = $urandom_range(0, 2);
      len1 = (r == 0) ? 50 : $urandom_range(1, 6);
      len2 = $urandom_range(1, 6);
      falls    = 0;
      prev_mv1 = 1'b1;
      for (int j = 0; j < 60; j++) begin
        @(posedge clk);
        #1;
        hit1 = (j == h1 && k1 != 1) || (j == h1 + 6);   // second pulse lands in WAIT
        oob1 = (k1 != 0) && (j >= h1) && (j < h1 + len1);
        hit2 = (j == h2 && k2 != 1) || (j == h2 + 5);
        oob2 = (k2 != 0) && (j >= h2) && (j < h2 + len2);
        if (j == h1) q1.push_back(elig(cyc));
        if (j == h2) q2.push_back(elig(cyc));
        @(negedge clk);
        if (j == h1 + 1) check("exit1_moveen", moveen1, 1'b0);
        if (j == h2 + 1) check("exit2_moveen", moveen2, 1'b0);
        if (prev_mv1 && !moveen1) falls++;
        prev_mv1 = moveen1;
      end
      if (r == 0) check("oob_hold_single_exit", falls, 1);
      @(posedge clk);
      #1;
      hit1 = 1'b0; hit2 = 1'b0; oob1 = 1'b0; oob2 = 1'b0;
    end

    // drop en mid-flight, then re-enable
    wait_both_fly("pre_en_drop");
    @(posedge clk);
    #1 en = 1'b0;
    q1.delete();
    q2.delete();
    @(negedge clk);
    @(negedge clk);
    check("en_drop_moveen", {moveen1, moveen2}, 2'b00);
    act = 0;
    repeat (20) begin
      @(negedge clk);
      act += int'(load1) + int'(load2) + int'(moveen1) + int'(moveen2);
    end
    check("en_low_no_activity", act, 0);
    @(posedge clk);
    #1 en = 1'b1;
    q1.push_back(elig(cyc));
    q2.push_back(elig(cyc));
    wait_both_fly("reenable");

    // reset in flight
    @(posedge clk);
    #1 rst = 1'b1;
    q1.delete();
    q2.delete();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("midflight_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    en = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
